// File: rtl/pe_pkg.sv
// Shared widths, field-slice helpers and set-operation encodings for the
// coverage processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_ANY      = 2'd0,
        MODE_ALL      = 2'd1,
        MODE_ONE      = 2'd2,
        MODE_TWO_PLUS = 2'd3
    } pe_mode_e;

    function automatic int diff_w(input int coord_w);
        return coord_w + 1;
    endfunction

    function automatic int sqr_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    function automatic int rsq_w(input int rad_w);
        return 2 * rad_w;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Derived widths for the default 4-bit coordinate/radius configuration.
    localparam int DIFF_W = diff_w(4);
    localparam int SQR_W  = sqr_w(4);
    localparam int RSQ_W  = rsq_w(4);

    // A {x,y} pair holds x in the upper half and y in the lower half.
    function automatic int xy_x_lsb(input int coord_w);
        return coord_w;
    endfunction

    function automatic int xy_y_lsb(input int coord_w);
        return 0;
    endfunction

    function automatic int cent_lsb(input int idx, input int coord_w);
        return idx * 2 * coord_w;
    endfunction

    function automatic int rad_lsb(input int idx, input int rad_w);
        return idx * rad_w;
    endfunction

endpackage

// File: rtl/pe_dist_lane.sv
// One circle's datapath: signed differences, squared distance and squared
// radius, then the boundary-mode compare against the S2 registers.
module pe_dist_lane
    import pe_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int RAD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_adv,
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    input  logic [COORD_W-1:0] i_cx,
    input  logic [COORD_W-1:0] i_cy,
    input  logic [RAD_W-1:0]   i_rad,
    input  logic               i_edge_incl,
    output logic               o_cov
);

    localparam int L_DIFF_W = diff_w(COORD_W);
    localparam int L_SQR_W  = sqr_w(COORD_W);
    localparam int L_RSQ_W  = rsq_w(RAD_W);
    localparam int L_CMP_W  = max_w(L_SQR_W, L_RSQ_W);

    logic signed [L_DIFF_W-1:0] w_dx, w_dy;
    logic signed [L_DIFF_W-1:0] r_dx, r_dy;
    logic        [RAD_W-1:0]    r_rad;
    logic signed [L_SQR_W-1:0]  w_dxe, w_dye, w_sum;
    logic        [L_RSQ_W-1:0]  w_r2;
    logic        [L_SQR_W-1:0]  r_d2;
    logic        [L_RSQ_W-1:0]  r_r2;
    logic        [L_CMP_W-1:0]  w_d2x, w_r2x;

    assign w_dx = $signed({1'b0, i_px}) - $signed({1'b0, i_cx});
    assign w_dy = $signed({1'b0, i_py}) - $signed({1'b0, i_cy});

    // Sign-extend before squaring so negative differences square correctly.
    assign w_dxe = L_SQR_W'(r_dx);
    assign w_dye = L_SQR_W'(r_dy);
    assign w_sum = w_dxe * w_dxe + w_dye * w_dye;
    assign w_r2  = L_RSQ_W'(r_rad) * L_RSQ_W'(r_rad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx  <= '0;
            r_dy  <= '0;
            r_rad <= '0;
            r_d2  <= '0;
            r_r2  <= '0;
        end else if (i_adv) begin
            r_dx  <= w_dx;
            r_dy  <= w_dy;
            r_rad <= i_rad;
            r_d2  <= $unsigned(w_sum);
            r_r2  <= w_r2;
        end
    end

    assign w_d2x = L_CMP_W'(r_d2);
    assign w_r2x = L_CMP_W'(r_r2);
    assign o_cov = i_edge_incl ? (w_d2x <= w_r2x) : (w_d2x < w_r2x);

endmodule

// File: rtl/pe_cov_pipe.sv
// Three-stage coverage PE: per-circle distance lanes, set operation over the
// coverage bits and a saturating per-frame hit counter under a global stall.
module pe_cov_pipe
    import pe_pkg::*;
#(
    parameter int NUM_CIRC = 3,
    parameter int COORD_W  = 4,
    parameter int RAD_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*COORD_W-1:0]            coord_i,
    input  logic [NUM_CIRC*2*COORD_W-1:0]   cent_i,
    input  logic [NUM_CIRC*RAD_W-1:0]       rad_i,
    input  logic [1:0]                      mode_i,
    input  logic                            edge_incl_i,
    input  logic                            last_i,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_CIRC-1:0]             covered_o,
    output logic                            hit_o,
    output logic [CNT_W-1:0]                cnt_o,
    output logic                            frame_done_o
);

    localparam int PC_W = $clog2(NUM_CIRC + 1);

    logic                w_adv;
    logic                r_v1, r_v2, r_v3;
    pe_mode_e            r_mode1, r_mode2;
    logic                r_edge1, r_edge2;
    logic                r_last1, r_last2;
    logic [NUM_CIRC-1:0] w_cov;
    logic [PC_W-1:0]     w_pop;
    logic                w_hit;
    logic [CNT_W-1:0]    w_base, w_cnt_nxt;
    logic [NUM_CIRC-1:0] r_cov;
    logic                r_hit;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_fd;

    assign w_adv    = !r_v3 | out_ready;
    assign in_ready = w_adv;

    for (genvar g = 0; g < NUM_CIRC; g++) begin : g_lane
        pe_dist_lane #(
            .COORD_W (COORD_W),
            .RAD_W   (RAD_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_adv       (w_adv),
            .i_px        (coord_i[xy_x_lsb(COORD_W) +: COORD_W]),
            .i_py        (coord_i[xy_y_lsb(COORD_W) +: COORD_W]),
            .i_cx        (cent_i[cent_lsb(g, COORD_W) + xy_x_lsb(COORD_W) +: COORD_W]),
            .i_cy        (cent_i[cent_lsb(g, COORD_W) + xy_y_lsb(COORD_W) +: COORD_W]),
            .i_rad       (rad_i[rad_lsb(g, RAD_W) +: RAD_W]),
            .i_edge_incl (r_edge2),
            .o_cov       (w_cov[g])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NUM_CIRC; i++) begin
            w_pop = w_pop + PC_W'(w_cov[i]);
        end
    end

    always_comb begin
        w_hit = 1'b0;
        case (r_mode2)
            MODE_ANY:      w_hit = (w_pop != '0);
            MODE_ALL:      w_hit = (w_pop == PC_W'(NUM_CIRC));
            MODE_ONE:      w_hit = (w_pop == PC_W'(1));
            MODE_TWO_PLUS: w_hit = (w_pop >= PC_W'(2));
            default:       w_hit = 1'b0;
        endcase
    end

    // S3 only loads when its previous beat has left (or never existed), and
    // its registers hold across bubbles, so they already carry the committed
    // count; a frame_done beat makes the next beat start from zero.
    assign w_base    = r_fd ? '0 : r_cnt;
    assign w_cnt_nxt = (w_base == '1) ? w_base : w_base + CNT_W'(w_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_mode1 <= MODE_ANY;
            r_mode2 <= MODE_ANY;
            r_edge1 <= 1'b0;
            r_edge2 <= 1'b0;
            r_last1 <= 1'b0;
            r_last2 <= 1'b0;
            r_cov   <= '0;
            r_hit   <= 1'b0;
            r_cnt   <= '0;
            r_fd    <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_mode1 <= pe_mode_e'(mode_i);
            r_edge1 <= edge_incl_i;
            r_last1 <= last_i;
            r_v2    <= r_v1;
            r_mode2 <= r_mode1;
            r_edge2 <= r_edge1;
            r_last2 <= r_last1;
            r_v3    <= r_v2;
            if (r_v2) begin
                r_cov <= w_cov;
                r_hit <= w_hit;
                r_cnt <= w_cnt_nxt;
                r_fd  <= r_last2;
            end
        end
    end

    assign out_valid    = r_v3;
    assign covered_o    = r_cov;
    assign hit_o        = r_hit;
    assign cnt_o        = r_cnt;
    assign frame_done_o = r_fd;

endmodule

// File: tb/tb_pe_cov_pipe.sv
// Scoreboard bench for pe_cov_pipe: directed beats push expectations, a
// negedge monitor pops and compares every accepted output beat.
module tb_pe_cov_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  coord_i;
    logic [23:0] cent_i;
    logic [11:0] rad_i;
    logic [1:0]  mode_i;
    logic        edge_incl_i;
    logic        last_i;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  covered_o;
    logic        hit_o;
    logic [7:0]  cnt_o;
    logic        frame_done_o;

    always #5 clk = ~clk;

    pe_cov_pipe #(
        .NUM_CIRC (3),
        .COORD_W  (4),
        .RAD_W    (4),
        .CNT_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .coord_i      (coord_i),
        .cent_i       (cent_i),
        .rad_i        (rad_i),
        .mode_i       (mode_i),
        .edge_incl_i  (edge_incl_i),
        .last_i       (last_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .covered_o    (covered_o),
        .hit_o        (hit_o),
        .cnt_o        (cnt_o),
        .frame_done_o (frame_done_o)
    );

    typedef struct packed {
        logic [2:0] cov;
        logic       hit;
        logic [7:0] cnt;
        logic       fd;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;
    int unsigned model_cnt = 0;
    int          last_fd_cnt = -1;
    int          fd_seen   = 0;
    logic        prev_stall = 1'b0;
    logic [13:0] snap;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic logic [2:0] model_cov(input logic [7:0] pt, input logic [23:0] cents,
                                             input logic [11:0] rads, input logic incl);
        logic [2:0] c;
        int px, py, cx, cy, r, d2, r2;
        px = int'(pt[7:4]);
        py = int'(pt[3:0]);
        for (int i = 0; i < 3; i++) begin
            cx = int'(cents[i*8+4 +: 4]);
            cy = int'(cents[i*8 +: 4]);
            r  = int'(rads[i*4 +: 4]);
            d2 = (px - cx) * (px - cx) + (py - cy) * (py - cy);
            r2 = r * r;
            c[i] = incl ? (d2 <= r2) : (d2 < r2);
        end
        return c;
    endfunction

    function automatic logic model_hit(input logic [2:0] c, input logic [1:0] mode);
        int pc;
        pc = int'(c[0]) + int'(c[1]) + int'(c[2]);
        case (mode)
            2'd0:    return pc >= 1;
            2'd1:    return pc == 3;
            2'd2:    return pc == 1;
            default: return pc >= 2;
        endcase
    endfunction

    task automatic send(input logic [7:0] pt, input logic [23:0] cents, input logic [11:0] rads,
                        input logic [1:0] mode, input logic incl, input logic last,
                        input logic [2:0] cov);
        exp_t e;
        int   w;
        e.cov = cov;
        e.hit = model_hit(cov, mode);
        if (e.hit && model_cnt < 255) model_cnt++;
        e.cnt = 8'(model_cnt);
        e.fd  = last;
        if (last) model_cnt = 0;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid    = 1'b1;
        coord_i     = pt;
        cent_i      = cents;
        rad_i       = rads;
        mode_i      = mode;
        edge_incl_i = incl;
        last_i      = last;
        w = 0;
        while (!in_ready) begin
            if (w >= 100) begin
                $display("FAIL in_ready_timeout: got 0, expected 1 within 100 cycles");
                $fatal(1);
            end
            w++;
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic send_auto(input logic [7:0] pt, input logic [23:0] cents, input logic [11:0] rads,
                             input logic [1:0] mode, input logic incl, input logic last);
        send(pt, cents, rads, mode, incl, last, model_cov(pt, cents, rads, incl));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        last_i   = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (prev_stall)
                check("stall_stable", int'({out_valid, covered_o, hit_o, cnt_o, frame_done_o}),
                      int'(snap));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("covered", int'(covered_o), int'(e.cov));
                    check("hit", int'(hit_o), int'(e.hit));
                    check("cnt", int'(cnt_o), int'(e.cnt));
                    check("frame_done", int'(frame_done_o), int'(e.fd));
                end
                if (frame_done_o) begin
                    last_fd_cnt = int'(cnt_o);
                    fd_seen++;
                end
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_valid, covered_o, hit_o, cnt_o, frame_done_o};
        end
    end

    initial begin
        int fd_before;
        rst = 1'b1;
        in_valid = 1'b0;
        coord_i = '0;
        cent_i = '0;
        rad_i = '0;
        mode_i = '0;
        edge_incl_i = 1'b0;
        last_i = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_cnt", int'(cnt_o), 0);
        check("rst_frame_done", int'(frame_done_o), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Boundary, extremes, then the four modes closing one frame.
        send(8'h30, 24'hFFFF00, {4'd0, 4'd0, 4'd3}, 2'd0, 1'b1, 1'b0, 3'b001);
        send(8'h30, 24'hFFFF00, {4'd0, 4'd0, 4'd3}, 2'd0, 1'b0, 1'b0, 3'b000);
        send(8'hFF, 24'h000000, {4'd0, 4'd0, 4'd15}, 2'd0, 1'b1, 1'b0, 3'b000);
        send(8'h00, 24'h000000, 12'h000, 2'd0, 1'b1, 1'b0, 3'b111);
        send(8'h00, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 3'b000);
        for (int m = 0; m < 4; m++)
            send(8'h55, 24'h5566FF, {4'd1, 4'd2, 4'd1}, 2'(m), 1'b1, m == 3, 3'b110);
        send(8'hFF, 24'h000000, 12'h000, 2'd0, 1'b1, 1'b1, 3'b000);
        idle();
        drain();
        check("nohit_last_total", last_fd_cnt, 0);

        // 8x8 grid frame: 13 points inside circle 2 with the boundary included.
        fd_before = fd_seen;
        for (int x = 1; x <= 8; x++)
            for (int y = 1; y <= 8; y++)
                send_auto({4'(x), 4'(y)}, 24'h440000, {4'd2, 4'd0, 4'd0}, 2'd0, 1'b1,
                          (x == 8) && (y == 8));
        idle();
        drain();
        check("grid_total", last_fd_cnt, 13);
        check("grid_fd_count", fd_seen - fd_before, 1);
        send(8'h44, 24'h440000, {4'd2, 4'd0, 4'd0}, 2'd0, 1'b1, 1'b0, 3'b100);
        send(8'h44, 24'h440000, {4'd2, 4'd0, 4'd0}, 2'd0, 1'b1, 1'b1, 3'b100);
        idle();
        drain();
        check("next_frame_total", last_fd_cnt, 2);

        // Backpressure: out_ready low for 5 cycles while 20 beats stream.
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send_auto({4'(i), 4'((i * 3) % 16)}, 24'h8822C3, {4'd5, 4'd3, 4'd4},
                              2'(i % 4), 1'(i % 2), i == 19);
                idle();
            end
            begin
                repeat (8) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Reset after 10 accepted beats of a frame that hits on every beat.
        for (int i = 0; i < 10; i++)
            send(8'h55, 24'h555555, {4'd1, 4'd1, 4'd1}, 2'd0, 1'b1, 1'b0, 3'b111);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_cnt", int'(cnt_o), 0);
        check("midrst_frame_done", int'(frame_done_o), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            send(8'h55, 24'h555555, {4'd1, 4'd1, 4'd1}, 2'd0, 1'b1, i == 2, 3'b111);
        idle();
        drain();
        check("post_rst_total", last_fd_cnt, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
